// File: rtl/seq_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_fetch_pkg
// Description : Shared constants and state encoding for the program store /
//               instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_fetch_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_INST_WIDTH = 12;

  // State codes are visible on the state output, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/seq_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_fetch_if
// Description : Load port, run control and fetch port of seq_fetch. The
//               master side is the loader/sequencer, the slave side is the
//               fetch stage itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_fetch_if #(
  parameter int ADDR_WIDTH = seq_fetch_pkg::DEF_ADDR_WIDTH,
  parameter int INST_WIDTH = seq_fetch_pkg::DEF_INST_WIDTH
) ();

  logic                  load_start;
  logic [INST_WIDTH-1:0] load_data;
  logic                  load_valid;
  logic                  load_last;
  logic                  load_ready;
  logic                  run;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] addr;
  logic [INST_WIDTH-1:0] inst;
  logic                  inst_en;
  logic                  done;
  logic [ADDR_WIDTH:0]   prog_len;
  logic [1:0]            state;

  modport master (
    output load_start, load_data, load_valid, load_last, run, abort, addr,
    input  load_ready, inst, inst_en, done, prog_len, state
  );

  modport slave (
    input  load_start, load_data, load_valid, load_last, run, abort, addr,
    output load_ready, inst, inst_en, done, prog_len, state
  );

endinterface
`default_nettype wire

// File: rtl/seq_fetch_ram.sv
`default_nettype none
// ============================================================================
// Module      : seq_fetch_ram
// Description : Simple dual-port program store, synchronous write and
//               registered synchronous read. Only the read register is
//               reset; the array keeps its contents across reset.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_fetch_ram #(
  parameter int ADDR_WIDTH = seq_fetch_pkg::DEF_ADDR_WIDTH,
  parameter int INST_WIDTH = seq_fetch_pkg::DEF_INST_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [INST_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [INST_WIDTH-1:0] rd_data_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [INST_WIDTH-1:0] mem_q [DEPTH];
  logic [INST_WIDTH-1:0] rd_data_q;

  // Write port: plain synchronous write, no reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read port: output register clears on reset and holds while not enabled.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/seq_fetch.sv
`default_nettype none
// ============================================================================
// Module      : seq_fetch
// Description : Program store and instruction fetch stage. Loaded serially
//               while idle; in run mode returns the word addressed by the
//               sequencer and flags it valid only when the registered read
//               provably belongs to the current address.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_fetch
  import seq_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int INST_WIDTH = DEF_INST_WIDTH
) (
  input  logic        clock,
  input  logic        reset,
  seq_fetch_if.slave  bus
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   prog_len_q, prog_len_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  rd_valid_q;

  logic                  w_wr_en;
  logic                  w_rd_en;
  logic                  w_addr_in_range;
  logic [INST_WIDTH-1:0] w_rd_data;

  // addr is zero-extended so that prog_len == DEPTH covers every address.
  assign w_addr_in_range = ({1'b0, bus.addr} < prog_len_q);
  assign w_wr_en         = (state_q == ST_LOAD) && bus.load_valid;
  assign w_rd_en         = (state_q == ST_RUN);

  seq_fetch_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INST_WIDTH (INST_WIDTH)
  ) u_ram (
    .clock     (clock),
    .reset     (reset),
    .wr_en_i   (w_wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (bus.load_data),
    .rd_en_i   (w_rd_en),
    .rd_addr_i (bus.addr),
    .rd_data_o (w_rd_data)
  );

  // Next-state logic: mode transitions plus write pointer / length updates.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    prog_len_d = prog_len_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.load_start) begin
          state_d    = ST_LOAD;
          wr_ptr_d   = '0;
          prog_len_d = '0;
        end else if (bus.run && (prog_len_q != '0)) begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        // A word offered alongside abort is still accepted: ready was high.
        if (w_wr_en) begin
          wr_ptr_d   = wr_ptr_q + 1'b1;
          prog_len_d = prog_len_q + 1'b1;
          // Last physical word ends the load; the pointer never wraps.
          if (bus.load_last || (&wr_ptr_q)) begin
            state_d = ST_IDLE;
          end
        end
        if (bus.abort) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (!w_addr_in_range) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, pointer and read-tracking registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      prog_len_q <= prog_len_d;
      rd_valid_q <= (state_q == ST_RUN);
      if (w_rd_en) begin
        rd_addr_q <= bus.addr;
      end
    end
  end

  assign bus.load_ready = (state_q == ST_LOAD);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.state      = state_q;
  assign bus.prog_len   = prog_len_q;
  assign bus.inst       = w_rd_data;
  // The read register only matches addr if it was filled in Run for this
  // very address; any address change therefore costs one bubble.
  assign bus.inst_en    = (state_q == ST_RUN) && rd_valid_q &&
                          (rd_addr_q == bus.addr) && w_addr_in_range;

endmodule
`default_nettype wire

// File: tb/tb_seq_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_fetch
// Description : Self-checking bench for seq_fetch: directed vector table,
//               directed multi-cycle sequences and random stimulus against
//               a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_fetch;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  seq_fetch_if #(.ADDR_WIDTH(8), .INST_WIDTH(12)) bus ();

  seq_fetch #(.ADDR_WIDTH(8), .INST_WIDTH(12)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit        rst;
    bit        ls;
    bit        lv;
    bit        ll;
    bit [11:0] ld;
    bit        run;
    bit        ab;
    bit [7:0]  addr;
  } in_t;

  typedef struct {
    in_t       i;
    bit [1:0]  st;
    bit        rdy;
    bit        en;
    bit        dn;
    bit [8:0]  len;
    bit        ci;
    bit [11:0] inst;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // Behavioural model of the program store as seen from outside.
  int        m_st;          // 0 idle, 1 load, 2 run, 3 done
  int        m_len;
  int        m_wp;
  bit [11:0] m_mem   [256];
  bit        m_known [256];
  bit [11:0] m_inst;
  bit        m_inst_known;
  bit        m_was_run;
  int        m_last_addr;
  bit        model_on = 1'b0;

  vec_t vt[$];
  vec_t nov;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic in_t mki(input bit rst, input bit ls, input bit lv,
                              input bit ll, input bit [11:0] ld, input bit run,
                              input bit ab, input bit [7:0] addr);
    in_t x;
    x.rst = rst; x.ls = ls; x.lv = lv; x.ll = ll;
    x.ld = ld; x.run = run; x.ab = ab; x.addr = addr;
    return x;
  endfunction

  function automatic void add(input in_t i, input bit [1:0] st, input bit rdy,
                              input bit en, input bit dn, input bit [8:0] len,
                              input bit ci, input bit [11:0] inst);
    vec_t v;
    v.i = i; v.st = st; v.rdy = rdy; v.en = en; v.dn = dn;
    v.len = len; v.ci = ci; v.inst = inst;
    vt.push_back(v);
  endfunction

  function automatic void model_check(input in_t x);
    bit exp_en;
    exp_en = (m_st == 2) && m_was_run && (m_last_addr == int'(x.addr)) &&
             (int'(x.addr) < m_len);
    chk("model.state",   32'(bus.state),    m_st);
    chk("model.ready",   32'(bus.load_ready), 32'(m_st == 1));
    chk("model.done",    32'(bus.done),     32'(m_st == 3));
    chk("model.len",     32'(bus.prog_len), m_len);
    chk("model.inst_en", 32'(bus.inst_en),  32'(exp_en));
    if (m_inst_known) chk("model.inst", 32'(bus.inst), 32'(m_inst));
  endfunction

  function automatic void model_update(input in_t x);
    int old;
    old = m_st;
    if (x.rst) begin
      m_st = 0; m_len = 0; m_wp = 0;
      m_inst = '0; m_inst_known = 1'b1; m_was_run = 1'b0;
      return;
    end
    m_was_run = (old == 2);
    case (old)
      0: if (!x.ab) begin
           if (x.ls) begin m_st = 1; m_wp = 0; m_len = 0; end
           else if (x.run && m_len != 0) m_st = 2;
         end
      1: begin
           if (x.lv) begin
             m_mem[m_wp] = x.ld; m_known[m_wp] = 1'b1;
             m_wp++; m_len++;
             if (x.ll || m_len == 256) m_st = 0;
           end
           if (x.ab) m_st = 0;
         end
      2: begin
           m_inst = m_mem[x.addr]; m_inst_known = m_known[x.addr];
           m_last_addr = int'(x.addr);
           if (x.ab) m_st = 0;
           else if (int'(x.addr) >= m_len) m_st = 3;
         end
      default: if (x.ab) m_st = 0;
    endcase
  endfunction

  // One clock: drive right after the edge, sample at the falling edge.
  task automatic cycle(input in_t x, input bit use_v, input vec_t v, input string tag);
    reset          = x.rst;
    bus.load_start = x.ls;
    bus.load_valid = x.lv;
    bus.load_last  = x.ll;
    bus.load_data  = x.ld;
    bus.run        = x.run;
    bus.abort      = x.ab;
    bus.addr       = x.addr;
    @(negedge clock);
    if (model_on) model_check(x);
    if (use_v) begin
      chk({tag, ".state"},   32'(bus.state),      32'(v.st));
      chk({tag, ".ready"},   32'(bus.load_ready), 32'(v.rdy));
      chk({tag, ".inst_en"}, 32'(bus.inst_en),    32'(v.en));
      chk({tag, ".done"},    32'(bus.done),       32'(v.dn));
      chk({tag, ".len"},     32'(bus.prog_len),   32'(v.len));
      if (v.ci) chk({tag, ".inst"}, 32'(bus.inst), 32'(v.inst));
    end
    @(posedge clock);
    model_update(x);
    #1;
  endtask

  task automatic step(input in_t x);
    cycle(x, 1'b0, nov, "");
  endtask

  initial begin
    bit [11:0] w255;
    bit [7:0]  prev_addr;
    in_t       x;

    for (int k = 0; k < 256; k++) begin m_mem[k] = '0; m_known[k] = 1'b0; end
    m_last_addr = 0;

    // Power-up reset, outputs not yet defined.
    @(posedge clock); #1;
    step(mki(1, 0, 0, 0, 0, 0, 0, 0));
    step(mki(1, 0, 0, 0, 0, 0, 0, 0));
    model_on = 1'b1;

    // Directed table: load 3 words, run, bubbles, done, abort priority.
    //         rst ls lv ll ld     run ab addr      st rdy en dn len ci inst
    add(mki(0, 0, 0, 0, 12'h000, 0, 0, 0), 0, 0, 0, 0, 0, 1, 12'h000);
    add(mki(0, 1, 0, 0, 12'h000, 0, 0, 0), 0, 0, 0, 0, 0, 1, 12'h000);
    add(mki(0, 0, 1, 0, 12'h101, 0, 0, 0), 1, 1, 0, 0, 0, 1, 12'h000);
    add(mki(0, 0, 1, 0, 12'h300, 0, 0, 0), 1, 1, 0, 0, 1, 1, 12'h000);
    add(mki(0, 0, 1, 1, 12'h700, 0, 0, 0), 1, 1, 0, 0, 2, 1, 12'h000);
    add(mki(0, 0, 0, 0, 12'h000, 0, 0, 0), 0, 0, 0, 0, 3, 1, 12'h000);
    add(mki(0, 0, 0, 0, 12'h000, 1, 0, 0), 0, 0, 0, 0, 3, 1, 12'h000);
    add(mki(0, 0, 0, 0, 12'h000, 0, 0, 0), 2, 0, 0, 0, 3, 1, 12'h000);
    add(mki(0, 0, 0, 0, 12'h000, 0, 0, 0), 2, 0, 1, 0, 3, 1, 12'h101);
    add(mki(0, 0, 0, 0, 12'h000, 0, 0, 1), 2, 0, 0, 0, 3, 1, 12'h101);
    add(mki(0, 0, 0, 0, 12'h000, 0, 0, 1), 2, 0, 1, 0, 3, 1, 12'h300);
    add(mki(0, 1, 0, 0, 12'h000, 0, 0, 1), 2, 0, 1, 0, 3, 1, 12'h300);
    add(mki(0, 0, 0, 0, 12'h000, 0, 0, 1), 2, 0, 1, 0, 3, 1, 12'h300);
    add(mki(0, 0, 0, 0, 12'h000, 0, 0, 3), 2, 0, 0, 0, 3, 1, 12'h300);
    add(mki(0, 0, 0, 0, 12'h000, 0, 0, 3), 3, 0, 0, 1, 3, 0, 12'h000);
    add(mki(0, 0, 0, 0, 12'h000, 1, 1, 3), 3, 0, 0, 1, 3, 0, 12'h000);
    add(mki(0, 0, 0, 0, 12'h000, 1, 1, 0), 0, 0, 0, 0, 3, 0, 12'h000);
    add(mki(0, 0, 0, 0, 12'h000, 0, 0, 0), 0, 0, 0, 0, 3, 0, 12'h000);
    foreach (vt[n]) cycle(vt[n].i, 1'b1, vt[n], $sformatf("vec%0d", n));

    // Full-depth load without load_last: auto return to Idle at 256 words.
    step(mki(0, 1, 0, 0, 0, 0, 0, 0));
    w255 = '0;
    for (int k = 0; k < 256; k++) begin
      x = mki(0, 0, 1, 0, 12'($urandom), 0, 0, 0);
      if (k == 255) w255 = x.ld;
      step(x);
    end
    chk("full.len",   32'(bus.prog_len),   32'd256);
    chk("full.state", 32'(bus.state),      32'd0);
    chk("full.ready", 32'(bus.load_ready), 32'd0);
    step(mki(0, 0, 0, 0, 0, 1, 0, 255));
    step(mki(0, 0, 0, 0, 0, 0, 0, 255));
    chk("full.w255",    32'(bus.inst),    32'(w255));
    chk("full.w255_en", 32'(bus.inst_en), 32'd1);
    step(mki(0, 0, 0, 0, 0, 0, 1, 255));
    chk("full.abort_state", 32'(bus.state), 32'd0);

    // Reset in the middle of a load, then run must be ignored.
    step(mki(0, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++) step(mki(0, 0, 1, 0, 12'(k + 9), 0, 0, 0));
    chk("rstload.len_before", 32'(bus.prog_len), 32'd5);
    step(mki(1, 0, 0, 0, 0, 0, 0, 0));
    chk("rstload.len",   32'(bus.prog_len), 32'd0);
    chk("rstload.state", 32'(bus.state),    32'd0);
    step(mki(0, 0, 0, 0, 0, 1, 0, 0));
    chk("rstload.run_ignored", 32'(bus.state), 32'd0);
    step(mki(0, 1, 0, 0, 0, 0, 0, 0));
    chk("rstload.reload", 32'(bus.state), 32'd1);
    step(mki(0, 0, 0, 0, 0, 0, 1, 0));
    chk("rstload.abort_len", 32'(bus.prog_len), 32'd0);

    // Random stimulus against the model.
    prev_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      int r;
      x.rst = ($urandom_range(0, 299) == 0);
      x.ab  = ($urandom_range(0, 49) == 0);
      x.ls  = ($urandom_range(0, 39) == 0);
      x.run = ($urandom_range(0, 7) == 0);
      x.lv  = ($urandom_range(0, 1) == 1);
      x.ll  = ($urandom_range(0, 29) == 0);
      x.ld  = 12'($urandom);
      r = $urandom_range(0, 9);
      if (r < 5)      x.addr = prev_addr;
      else if (r < 9) x.addr = 8'($urandom_range(0, m_len + 1));
      else            x.addr = 8'($urandom);
      prev_addr = x.addr;
      step(x);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_fetch.md
Name: seq_fetch

Overview:
- Program store and instruction fetch stage directly upstream of the sequencer.
- Loaded serially over a valid/ready port while idle.
- In run mode it returns the 12-bit instruction addressed by the sequencer's `next` output, on `inst`, qualified by `inst_en`.
- `inst_en` is asserted only when `inst` provably belongs to the current address, so the sequencer holds (no advance) on fetch bubbles.

Parameters:
- ADDR_WIDTH, 8, program address width; matches sequencer `next`.
- INST_WIDTH, 12, instruction word width.
- DEPTH, 2**ADDR_WIDTH, program words.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- load_start  in  1  pulse; in Idle, begins a load at word 0.
- load_data  in  INST_WIDTH  program word.
- load_valid  in  1  load_data valid.
- load_last  in  1  qualifies the final word, with load_valid.
- load_ready  out  1  high only in Load.
- run  in  1  pulse; in Idle with prog_len != 0, enters Run.
- abort  in  1  leaves Load/Run/Done and returns to Idle.
- addr  in  ADDR_WIDTH  fetch address (sequencer `next`).
- inst  out  INST_WIDTH  fetched instruction (registered).
- inst_en  out  1  inst valid for the current addr.
- done  out  1  addr ran past the program end.
- prog_len  out  ADDR_WIDTH+1  number of loaded words, 0..DEPTH.
- state  out  2  Idle=0, Load=1, Run=2, Done=3.

Behaviour:
- Reset (any state, mid-load or mid-run):
  - state=Idle; prog_len=0; inst=0; inst_en=0; load_ready=0; done=0; wr_ptr=0; rd_valid_q=0.
  - RAM contents are not cleared; a reload is required because prog_len=0.
- Idle:
  - Priority: abort > load_start > run.
  - load_start -> Load, with wr_ptr=0 and prog_len=0.
  - run with prog_len!=0 -> Run.
  - run with prog_len==0 is ignored.
- Load:
  - A write occurs on load_valid & load_ready: mem[wr_ptr]=load_data, wr_ptr+1, prog_len+1.
  - Exit to Idle after the write carrying load_last, or after the write at wr_ptr==DEPTH-1; prog_len=DEPTH in the latter case; no wrap.
  - abort -> Idle; prog_len keeps the words written so far.
  - run and load_start are ignored.
- Run:
  - Each cycle reads mem[addr] into the inst register and records rd_addr_q=addr.
  - rd_valid_q=1 iff the state was Run in the previous cycle.
  - inst_en = state==Run & rd_valid_q & (rd_addr_q==addr) & (addr<prog_len).
  - addr >= prog_len -> Done, with inst_en=0 in that cycle.
  - abort -> Idle, with inst_en=0 from the next cycle.
  - load_start is ignored.
- Done:
  - done=1, inst_en=0.
  - abort -> Idle.
  - run and load_start are ignored.
  - The sequencer must be reset externally before the next run; this block never drives the address.
- Latency:
  - run sampled in cycle 0 -> Run in cycle 1 -> first inst_en in cycle 2.
  - After each address change there is one bubble cycle (inst_en=0).
  - Sustained rate is 1 instruction per 2 cycles.
  - An unchanged addr (e.g. jump-to-self) gives inst_en every cycle.
- Widths: prog_len compare is unsigned with ADDR_WIDTH+1 bits; addr is zero-extended.
- inst holds its last value when not in Run.

Decomposition:
- Shared header with constants: state codes (Idle/Load/Run/Done), default ADDR_WIDTH/INST_WIDTH.
- One sub-module, seq_fetch_ram:
  - simple dual-port DEPTH x INST_WIDTH;
  - synchronous write and synchronous registered read;
  - no reset on the array;
  - block-RAM inferable.
- FSM, pointers and qualification logic live in seq_fetch.

Test Plan:
- Load 0x101,0x300,0x7_00 (load_last on the third word) -> prog_len=3, state=Idle; load_ready is high only during the 3 Load cycles.
- Run with addr=0 held -> inst_en=0 in cycles 0-1, and inst=0x101 with inst_en=1 in cycle 2. Then drive addr=1 -> one bubble, then inst=0x300 with inst_en=1.
- With prog_len=3, drive addr=3 in Run -> state=Done, done=1, inst_en=0; abort -> state=Idle, done=0.
- Load 256 words without load_last -> prog_len=256, auto return to Idle, load_ready=0, and word 255 reads back correctly.
- Assert reset mid-load after 5 words, then load_start/run -> prog_len=0 after reset, and run is ignored (state stays Idle).
- load_start in Run, then abort and run asserted together in Idle -> load_start ignored; abort wins, state stays Idle.
